// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer (master) and the
// datapath/memory side (slave).
interface multicycle_ctrl_if;
    logic [15:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        br_cond;
    logic        imem_req;
    logic        dmem_req;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        memWrite;
    logic        MemtoReg;
    logic [3:0]  ALU_operation;
    logic [2:0]  state;
    logic        hlt;
    logic [15:0] retire_cnt;

    modport master (
        input  instr, imem_ack, dmem_ack, br_cond,
        output imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc,
               MemRead, memWrite, MemtoReg, ALU_operation, state, hlt, retire_cnt
    );

    modport slave (
        output instr, imem_ack, dmem_ack, br_cond,
        input  imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc,
               MemRead, memWrite, MemtoReg, ALU_operation, state, hlt, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky HALT
// and a wrapping retired-instruction counter.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] retire_q, retire_d;
    logic        hold_q;
    logic        alu_imm;

    assign alu_imm = ((opcode_q >= 4'd4) && (opcode_q <= 4'd6)) ||
                     ((opcode_q >= 4'd8) && (opcode_q <= 4'd13));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            opcode_q <= '0;
            retire_q <= '0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            retire_q <= retire_d;
            hold_q   <= 1'b0;
        end
    end

    // hold_q keeps every output quiet (and acks ignored) on the cycle right
    // after a reset edge, so an aborted request is only re-issued after release.
    always_comb begin
        state_d           = state_q;
        opcode_d          = opcode_q;
        retire_d          = retire_q;
        bus.imem_req      = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.PCSrc         = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrc        = 1'b0;
        bus.MemRead       = 1'b0;
        bus.memWrite      = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.ALU_operation = '0;
        bus.hlt           = 1'b0;
        bus.state         = state_q;
        bus.retire_cnt    = retire_q;

        if (!hold_q) begin
            case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        bus.IRWrite = 1'b1;
                        opcode_d    = bus.instr[15:12];
                        state_d     = DECODE;
                    end
                end
                DECODE: begin
                    state_d = (opcode_q == OP_HLT) ? HALT : EXEC;
                end
                EXEC: begin
                    bus.ALU_operation = opcode_q;
                    bus.ALUSrc        = alu_imm;
                    if (opcode_q == OP_LW || opcode_q == OP_SW) begin
                        state_d = MEM;
                    end else if (opcode_q == OP_B || opcode_q == OP_BR) begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = bus.br_cond;
                        retire_d    = retire_q + 16'd1;
                        state_d     = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
                MEM: begin
                    bus.dmem_req      = 1'b1;
                    bus.ALU_operation = opcode_q;
                    bus.MemRead       = (opcode_q == OP_LW);
                    bus.memWrite      = (opcode_q == OP_SW);
                    if (bus.dmem_ack) begin
                        if (opcode_q == OP_LW) begin
                            state_d = WB;
                        end else begin
                            bus.PCWrite = 1'b1;
                            retire_d    = retire_q + 16'd1;
                            state_d     = FETCH;
                        end
                    end
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                    bus.MemtoReg = (opcode_q == OP_LW);
                    retire_d     = retire_q + 16'd1;
                    state_d      = FETCH;
                end
                HALT: begin
                    bus.hlt = 1'b1;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes a per-instruction
// expectation derived from the ISA timing rules, the monitor checks it at retire.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_if io();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(io));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] trace;
        int          ncyc;
        int          imem_n;
        int          rd_n;
        int          wr_n;
        logic [3:0]  alu;
        logic [3:0]  mem_alu;
        logic        alusrc;
        logic        regw;
        logic        m2r;
        logic        pcsrc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] push3(input logic [63:0] t, input logic [2:0] s);
        return {t[60:0], s};
    endfunction

    // Expected observation of one instruction, from fetch start to its retire cycle.
    function automatic exp_t model(input logic [15:0] ins, input int im, input int dm,
                                   input logic br, input logic [15:0] cnt);
        exp_t e;
        logic [3:0] op;
        logic is_mem, is_br, has_wb;
        op     = ins[15:12];
        is_mem = (op == 4'h8) || (op == 4'h9);
        is_br  = (op == 4'hC) || (op == 4'hD);
        has_wb = !is_br && (op != 4'h9);
        e.trace = '0;
        for (int i = 0; i <= im; i++) e.trace = push3(e.trace, 3'd0);
        e.trace = push3(e.trace, 3'd1);
        e.trace = push3(e.trace, 3'd2);
        if (is_mem) for (int i = 0; i <= dm; i++) e.trace = push3(e.trace, 3'd3);
        if (has_wb) e.trace = push3(e.trace, 3'd4);
        e.ncyc    = im + 3 + (is_mem ? dm + 1 : 0) + (has_wb ? 1 : 0);
        e.imem_n  = im + 1;
        e.rd_n    = (op == 4'h8) ? dm + 1 : 0;
        e.wr_n    = (op == 4'h9) ? dm + 1 : 0;
        e.alu     = op;
        e.mem_alu = is_mem ? op : 4'h0;
        e.alusrc  = ((op >= 4'd4) && (op <= 4'd6)) || ((op >= 4'd8) && (op <= 4'd13));
        e.regw    = has_wb;
        e.m2r     = (op == 4'h8);
        e.pcsrc   = is_br ? br : 1'b0;
        e.cnt     = cnt;
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [63:0] m_trace;
    int          m_ncyc, m_imem, m_rd, m_wr;
    logic [3:0]  m_alu, m_malu;
    logic        m_alusrc, m_regw, m_m2r, m_active, m_bad;
    exp_t        m_e;

    initial m_active = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active || io.imem_req) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_trace = '0; m_ncyc = 0; m_imem = 0; m_rd = 0; m_wr = 0;
                m_alu = '0; m_malu = '0; m_alusrc = 1'b0; m_regw = 1'b0;
                m_m2r = 1'b0; m_bad = 1'b0;
            end
            m_trace = push3(m_trace, io.state);
            m_ncyc++;
            m_imem += int'(io.imem_req);
            m_rd   += int'(io.MemRead);
            m_wr   += int'(io.memWrite);
            if (io.state == 3'd2) begin
                m_alu    = io.ALU_operation;
                m_alusrc = io.ALUSrc;
            end else begin
                if (io.ALUSrc) m_bad = 1'b1;
                if (io.state == 3'd3) m_malu = io.ALU_operation;
                else if (io.ALU_operation != 4'h0) m_bad = 1'b1;
            end
            if (io.hlt) m_bad = 1'b1;
            m_regw = m_regw | io.RegWrite;
            m_m2r  = m_m2r | io.MemtoReg;
            if (io.PCWrite) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_retire: got retire with empty scoreboard, expected none");
                end else begin
                    m_e = sb.pop_front();
                    chk("state_trace", m_trace, m_e.trace);
                    chk("cycles", 64'(m_ncyc), 64'(m_e.ncyc));
                    chk("imem_req_cycles", 64'(m_imem), 64'(m_e.imem_n));
                    chk("MemRead_cycles", 64'(m_rd), 64'(m_e.rd_n));
                    chk("memWrite_cycles", 64'(m_wr), 64'(m_e.wr_n));
                    chk("exec_ALU_operation", 64'(m_alu), 64'(m_e.alu));
                    chk("mem_ALU_operation", 64'(m_malu), 64'(m_e.mem_alu));
                    chk("exec_ALUSrc", 64'(m_alusrc), 64'(m_e.alusrc));
                    chk("RegWrite", 64'(m_regw), 64'(m_e.regw));
                    chk("MemtoReg", 64'(m_m2r), 64'(m_e.m2r));
                    chk("PCSrc", 64'(io.PCSrc), 64'(m_e.pcsrc));
                    chk("retire_cnt_before", 64'(io.retire_cnt), 64'(m_e.cnt));
                    chk("stray_outputs", 64'(m_bad), 64'(0));
                end
                m_active = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit dmem, output bit ok);
        int n;
        n = 0;
        while ((dmem ? io.dmem_req : io.imem_req) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        ok = (n < 50);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no request in 50 cycles, expected request", dmem ? "dmem" : "imem");
        end
    endtask

    task automatic issue(input logic [15:0] ins, input int im, input int dm, input logic br,
                         input bit push, input bit abort);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) return;
        io.br_cond = br;
        if (push) begin
            sb.push_back(model(ins, im, dm, br, exp_cnt));
            exp_cnt = exp_cnt + 16'd1;
        end
        for (int i = 0; i < im; i++) begin
            io.dmem_ack = 1'($urandom_range(0, 1));
            tick();
        end
        io.dmem_ack = 1'b0;
        io.imem_ack = 1'b1;
        io.instr    = ins;
        tick();
        io.imem_ack = 1'($urandom_range(0, 1));
        io.instr    = 16'($urandom);
        tick();
        io.imem_ack = 1'b0;
        if (ins[15:12] == 4'h8 || ins[15:12] == 4'h9) begin
            wait_req(1'b1, ok);
            if (!ok) return;
            if (abort) begin
                chk("abort_memWrite_pre", 64'(io.memWrite), 64'(1));
                rst_n = 1'b0;
                tick();
                chk("abort_state", 64'(io.state), 64'(0));
                chk("abort_memWrite", 64'(io.memWrite), 64'(0));
                chk("abort_dmem_req", 64'(io.dmem_req), 64'(0));
                chk("abort_retire_cnt", 64'(io.retire_cnt), 64'(0));
                rst_n = 1'b1;
                exp_cnt = '0;
                tick();
                chk("abort_refetch_req", 64'(io.imem_req), 64'(1));
                return;
            end
            for (int i = 0; i < dm; i++) begin
                io.imem_ack = 1'($urandom_range(0, 1));
                tick();
            end
            io.imem_ack = 1'b0;
            io.dmem_ack = 1'b1;
            tick();
            io.dmem_ack = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'(0));
        chk("retire_cnt_after_drain", 64'(io.retire_cnt), 64'(exp_cnt));
    endtask

    task automatic random_batch(input int n);
        logic [15:0] ins;
        for (int k = 0; k < n; k++) begin
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            issue(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        io.instr = '0; io.imem_ack = 1'b0; io.dmem_ack = 1'b0; io.br_cond = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_state", 64'(io.state), 64'(0));
        chk("reset_imem_req", 64'(io.imem_req), 64'(0));
        chk("reset_retire_cnt", 64'(io.retire_cnt), 64'(0));
        chk("reset_hlt", 64'(io.hlt), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("release_imem_req", 64'(io.imem_req), 64'(1));

        issue(16'h0123, 0, 0, 1'b0, 1'b1, 1'b0);
        issue(16'h8123, 3, 2, 1'b0, 1'b1, 1'b0);
        issue(16'hC005, 0, 0, 1'b1, 1'b1, 1'b0);
        issue(16'hC005, 1, 0, 1'b0, 1'b1, 1'b0);
        issue(16'hE042, 0, 0, 1'b0, 1'b1, 1'b0);
        issue(16'h9abc, 2, 0, 1'b0, 1'b1, 1'b0);
        random_batch(150);
        drain();

        issue(16'hF000, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            io.imem_ack = 1'($urandom_range(0, 1));
            io.dmem_ack = 1'($urandom_range(0, 1));
            chk("halt_state", 64'(io.state), 64'(5));
            chk("halt_hlt", 64'(io.hlt), 64'(1));
            chk("halt_reqs", 64'({io.imem_req, io.dmem_req, io.PCWrite, io.RegWrite}), 64'(0));
            chk("halt_retire_cnt", 64'(io.retire_cnt), 64'(exp_cnt));
            tick();
        end
        io.imem_ack = 1'b0;
        io.dmem_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("halt_reset_state", 64'(io.state), 64'(0));
        chk("halt_reset_hlt", 64'(io.hlt), 64'(0));
        chk("halt_reset_imem_req", 64'(io.imem_req), 64'(0));
        rst_n = 1'b1;
        exp_cnt = '0;
        tick();
        chk("halt_release_imem_req", 64'(io.imem_req), 64'(1));

        issue(16'h0777, 0, 0, 1'b0, 1'b1, 1'b0);
        issue(16'h9555, 1, 2, 1'b0, 1'b0, 1'b1);

        wait_req(1'b0, ok);
        force dut.retire_q = 16'hFFFF;
        @(negedge clk);
        release dut.retire_q;
        exp_cnt = 16'hFFFF;
        issue(16'h0001, 0, 0, 1'b0, 1'b1, 1'b0);
        issue(16'h0002, 0, 0, 1'b0, 1'b1, 1'b0);
        random_batch(40);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
